mux4x1_rr_ctrl: RTL and testbench



---
 rtl/mux4x1_rr_ctrl_pkg.sv | 23 ++
 rtl/mux4x1_rr_ctrl_if.sv | 25 ++
 rtl/mux4x1_rr_ctrl_rr_pick4.sv | 28 ++
 rtl/mux4x1_rr_ctrl.sv | 109 ++++++++++
 tb/tb_mux4x1_rr_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux4x1_rr_ctrl_pkg.sv
// Shared constants and types for the round-robin 4:1 mux select controller.
package mux4x1_rr_ctrl_pkg;

    localparam int NUM_SRC = 4;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] SETTLE_ENC = 2'd1;
    localparam logic [1:0] HOLD_ENC   = 2'd2;

    // Reset value of the last-granted pointer; makes source 0 first in line.
    localparam logic [1:0] LAST_RESET = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = IDLE_ENC,
        SETTLE = SETTLE_ENC,
        HOLD   = HOLD_ENC
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4x1_rr_ctrl_if.sv
// Request/ack, mux select/feedback and downstream valid/ready bundle.
interface mux4x1_rr_ctrl_if
    import mux4x1_rr_ctrl_pkg::*;
#(
    parameter int W = 4
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] ack;
    logic [1:0]         select;
    logic [W-1:0]       mux_data;
    logic [W-1:0]       out_data;
    logic [1:0]         out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  req, mux_data, out_ready,
        output ack, select, out_data, out_src, out_valid
    );

    modport slave (
        output req, mux_data, out_ready,
        input  ack, select, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux4x1_rr_ctrl_rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping mod 4.
module mux4x1_rr_ctrl_rr_pick4
    import mux4x1_rr_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         winner,
    output logic               any
);
    logic [1:0] cand [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign cand[gi] = last + 2'(gi + 1);
        end
    endgenerate

    // Scan from the farthest candidate back so the nearest requester wins.
    always_comb begin
        winner = last;
        any    = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
            end
        end
    end
endmodule

// File: rtl/mux4x1_rr_ctrl.sv
// Round-robin select controller for an external 4:1 mux with settle-then-capture.
// Optional per-source grant counters via MUX4X1_RR_CTRL_STATS_EN.
module mux4x1_rr_ctrl
    import mux4x1_rr_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    mux4x1_rr_ctrl_if.master bus
`ifdef MUX4X1_RR_CTRL_STATS_EN
    ,
    output logic [31:0]      grant_cnt
`endif
);
    state_t             state_reg, state_next;
    logic [1:0]         select_reg, select_next;
    logic [NUM_SRC-1:0] ack_reg, ack_next;
    logic [W-1:0]       out_data_reg, out_data_next;
    logic [1:0]         out_src_reg, out_src_next;
    logic               out_valid_reg, out_valid_next;
    logic [1:0]         last_reg, last_next;
    logic [1:0]         winner;
    logic               any;

    mux4x1_rr_ctrl_rr_pick4 rr_pick4 (
        .req    (bus.req),
        .last   (last_reg),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            select_reg    <= '0;
            ack_reg       <= '0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_valid_reg <= 1'b0;
            last_reg      <= LAST_RESET;
        end else begin
            state_reg     <= state_next;
            select_reg    <= select_next;
            ack_reg       <= ack_next;
            out_data_reg  <= out_data_next;
            out_src_reg   <= out_src_next;
            out_valid_reg <= out_valid_next;
            last_reg      <= last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        select_next    = select_reg;
        ack_next       = '0;
        out_data_next  = out_data_reg;
        out_src_next   = out_src_reg;
        out_valid_next = out_valid_reg;
        last_next      = last_reg;
        case (state_reg)
            IDLE: begin
                if (any) begin
                    select_next = winner;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                // select has been stable a full cycle, so mux_data is valid now.
                out_data_next  = bus.mux_data;
                out_src_next   = select_reg;
                out_valid_next = 1'b1;
                ack_next       = onehot4(select_reg);
                last_next      = select_reg;
                state_next     = HOLD;
            end
            HOLD: begin
                if (out_valid_reg && bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ack       = ack_reg;
    assign bus.select    = select_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;
    assign bus.out_valid = out_valid_reg;

`ifdef MUX4X1_RR_CTRL_STATS_EN
    logic [7:0] cnt_reg [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (ack_reg[gi] && (cnt_reg[gi] != 8'hFF)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
                end
            end
            assign grant_cnt[8*gi +: 8] = cnt_reg[gi];
        end
    endgenerate
`endif
endmodule

// File: tb/tb_mux4x1_rr_ctrl.sv
// Scoreboard bench for mux4x1_rr_ctrl: stimulus queues expected words, a monitor checks handshakes.
module tb_mux4x1_rr_ctrl;
    typedef struct {
        logic [1:0] src;
        logic [3:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] mux_in [4];
    exp_t       exp_q [$];
    int         total = 0;
    int         bad = 0;
    int         cycle = 0;
    int         hs_count = 0;
    int         last_hs_cycle = 0;
    bit         hs_seen = 1'b0;
    bit         check_period = 1'b0;
    bit         auto_src = 1'b0;

    mux4x1_rr_ctrl_if #(.W(4)) bus ();

    assign bus.mux_data = mux_in[bus.select];

`ifdef MUX4X1_RR_CTRL_STATS_EN
    logic [31:0] grant_cnt;
    mux4x1_rr_ctrl #(.W(4)) dut (.clk(clk), .reset(reset), .bus(bus), .grant_cnt(grant_cnt));
`else
    mux4x1_rr_ctrl #(.W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Sources that re-present new data in the cycle after their ack.
    initial forever begin
        @(negedge clk);
        if (auto_src) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) mux_in[i] = mux_in[i] + 4'd8;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted word.
    initial forever begin
        @(negedge clk);
        if (!reset && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got src=%0d data=%0h, required no word", bus.out_src, bus.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.out_src !== e.src || bus.out_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_word: got src=%0d data=%0h, required src=%0d data=%0h",
                             bus.out_src, bus.out_data, e.src, e.data);
                end else begin
                    $display("word src=%0d data=%0h ok", bus.out_src, bus.out_data);
                end
            end
            if (check_period && hs_seen) begin
                total++;
                if (cycle - last_hs_cycle != 3) begin
                    bad++;
                    $display("FAIL word_period: got %0d cycles, required 3", cycle - last_hs_cycle);
                end
            end
            hs_seen = 1'b1;
            last_hs_cycle = cycle;
            hs_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] d);
        exp_t e;
        e.src = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int src);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (bus.ack[src]) seen = 1'b1;
        end
        check($sformatf("ack%0d_seen", src), 32'(seen), 32'd1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int n = 0; n < budget && hs_count < target; n++) step();
        check("hs_reached", 32'(hs_count >= target), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) mux_in[i] = 4'h0;

        // T1: reset values, single requester latency
        do_reset();
        check("rst_select", 32'(bus.select), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_src", 32'(bus.out_src), 32'd0);
        mux_in[0] = 4'hA;
        bus.req = 4'b0001;
        push(2'd0, 4'hA);
        step();
        check("t1_select_c1", 32'(bus.select), 32'd0);
        check("t1_valid_c1", 32'(bus.out_valid), 32'd0);
        check("t1_ack_c1", 32'(bus.ack), 32'd0);
        step();
        check("t1_ack_c2", 32'(bus.ack), 32'b0001);
        check("t1_valid_c2", 32'(bus.out_valid), 32'd1);
        check("t1_data_c2", 32'(bus.out_data), 32'hA);
        bus.req = 4'b0000;
        step();
        check("t1_valid_c3", 32'(bus.out_valid), 32'd0);
        check("t1_ack_c3", 32'(bus.ack), 32'd0);
        repeat (2) step();

        // T2: all four requesting, rotation and 3-cycle period
        do_reset();
        for (int i = 0; i < 4; i++) mux_in[i] = 4'(i + 1);
        push(2'd0, 4'h1);
        push(2'd1, 4'h2);
        push(2'd2, 4'h3);
        push(2'd3, 4'h4);
        push(2'd0, 4'h9);
        auto_src = 1'b1;
        hs_seen = 1'b0;
        check_period = 1'b1;
        bus.req = 4'b1111;
        wait_hs(hs_count + 5, 40);
        bus.req = 4'b0000;
        check_period = 1'b0;
        auto_src = 1'b0;
        repeat (4) step();

        // T3: backpressure while another source waits
        do_reset();
        mux_in[2] = 4'h5;
        bus.out_ready = 1'b0;
        bus.req = 4'b0100;
        push(2'd2, 4'h5);
        wait_ack(2);
        bus.req = 4'b0000;
        mux_in[0] = 4'h7;
        bus.req = 4'b0001;
        push(2'd0, 4'h7);
        for (int n = 0; n < 5; n++) begin
            step();
            check("t3_hold_data", 32'(bus.out_data), 32'h5);
            check("t3_hold_src", 32'(bus.out_src), 32'd2);
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_ack", 32'(bus.ack), 32'd0);
            check("t3_hold_select", 32'(bus.select), 32'd2);
        end
        bus.out_ready = 1'b1;
        step();
        check("t3_valid_drop", 32'(bus.out_valid), 32'd0);
        wait_ack(0);
        bus.req = 4'b0000;
        repeat (3) step();

        // T4: wrap from source 3 to source 0
        do_reset();
        mux_in[3] = 4'hC;
        bus.req = 4'b1000;
        push(2'd3, 4'hC);
        wait_ack(3);
        mux_in[3] = 4'hE;
        mux_in[0] = 4'hD;
        bus.req = 4'b1001;
        push(2'd0, 4'hD);
        push(2'd3, 4'hE);
        wait_ack(0);
        bus.req = 4'b1000;
        wait_ack(3);
        bus.req = 4'b0000;
        repeat (3) step();

        // T5: asynchronous reset during SETTLE
        do_reset();
        mux_in[1] = 4'h6;
        bus.req = 4'b0010;
        step();
        check("t5_select_settle", 32'(bus.select), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_ack", 32'(bus.ack), 32'd0);
        check("t5_rst_select", 32'(bus.select), 32'd0);
        bus.req = 4'b0000;
        repeat (2) step();
        reset = 1'b0;
        mux_in[0] = 4'h8;
        mux_in[1] = 4'h9;
        bus.req = 4'b0011;
        push(2'd0, 4'h8);
        push(2'd1, 4'h9);
        wait_ack(0);
        bus.req = 4'b0010;
        wait_ack(1);
        bus.req = 4'b0000;
        repeat (3) step();

`ifdef MUX4X1_RR_CTRL_STATS_EN
        // T6: saturating grant counter
        do_reset();
        mux_in[1] = 4'h3;
        for (int n = 0; n < 300; n++) push(2'd1, 4'h3);
        bus.req = 4'b0010;
        wait_hs(hs_count + 300, 1200);
        bus.req = 4'b0000;
        repeat (4) step();
        check("t6_grant_cnt", grant_cnt, 32'h0000FF00);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
